// File: rtl/msg_packer_if.sv
// Stream-in / frame-out bundle for msg_packer: character stream on the slave
// side, packed frame plus error status toward the encryptor.
interface msg_packer_if #(
  parameter int MSG_LEN = 6
);
  localparam int LW = $clog2(MSG_LEN + 1);

  // Both channels use plain valid/ready: a transfer happens on a rising clk
  // edge where valid and ready are both high; valid holds its payload until then.
  logic [7:0]           in_char;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [8*MSG_LEN-1:0] frame_out;
  logic [LW-1:0]        frame_len;
  logic                 frame_valid;
  logic                 frame_ready;
  logic                 err_invalid;
  logic [7:0]           err_count;
  logic                 dbg_state;

  modport slave (
    input  in_char, in_valid, in_last, frame_ready,
    output in_ready, frame_out, frame_len, frame_valid, err_invalid, err_count, dbg_state
  );

  modport master (
    output in_char, in_valid, in_last, frame_ready,
    input  in_ready, frame_out, frame_len, frame_valid, err_invalid, err_count, dbg_state
  );
endinterface

// File: rtl/msg_packer.sv
// Packs a validated character stream into fixed MSG_LEN-byte frames (slot 0 first).
// Define MSG_PACKER_SANITIZE_EN to store invalid bytes as SUB_CHAR instead of dropping them.
module msg_packer #(
  parameter int         MSG_LEN  = 6,
  parameter logic [7:0] PAD_CHAR = 8'h20,
  parameter logic [7:0] SUB_CHAR = 8'h58
) (
  input logic          clk,
  input logic          rst_n,
  msg_packer_if.slave  bus
);
  localparam int LW = $clog2(MSG_LEN + 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic [MSG_LEN-1:0][7:0] frame_q, frame_d;
  logic [LW-1:0]           frame_len_q, frame_len_d;
  logic                    in_ready_q, in_ready_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    err_invalid_q, err_invalid_d;
  logic [7:0]              err_count_q, err_count_d;

  logic                    accept;
  logic                    char_ok;
  logic                    store;
  logic                    close;
  logic [7:0]              store_char;
  logic [LW-1:0]           cnt_next;

  function automatic logic is_legal(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ||
           ((c >= 8'h61) && (c <= 8'h7A)) ||
           (c == 8'h20);
  endfunction

  always_comb begin
    accept     = bus.in_valid && in_ready_q && (state_q == FILL);
    char_ok    = is_legal(bus.in_char);
    // Substitution is harmless when invalid bytes are dropped: they never get stored.
    store_char = char_ok ? bus.in_char : SUB_CHAR;
`ifdef MSG_PACKER_SANITIZE_EN
    store      = accept;
`else
    store      = accept && char_ok;
`endif
    close      = accept && (bus.in_last || (store && (idx_q == LW'(MSG_LEN - 1))));
    cnt_next   = idx_q + LW'(store);

    state_d       = state_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    frame_len_d   = frame_len_q;
    in_ready_d    = in_ready_q;
    frame_valid_d = frame_valid_q;
    err_invalid_d = accept && !char_ok;
    err_count_d   = err_count_q;

    if (err_invalid_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    case (state_q)
      FILL: begin
        in_ready_d = 1'b1;
        if (store) begin
          frame_d[idx_q] = store_char;
          idx_d          = cnt_next;
        end
        if (close) begin
          idx_d = '0;
          // An empty frame is silently discarded and filling simply restarts.
          if (cnt_next != '0) begin
            for (int k = 0; k < MSG_LEN; k++) begin
              if (k >= int'(cnt_next)) frame_d[k] = PAD_CHAR;
            end
            frame_len_d   = cnt_next;
            state_d       = HOLD;
            in_ready_d    = 1'b0;
            frame_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.frame_ready) begin
          state_d       = FILL;
          idx_d         = '0;
          in_ready_d    = 1'b1;
          frame_valid_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      idx_q         <= '0;
      frame_q       <= {MSG_LEN{PAD_CHAR}};
      frame_len_q   <= '0;
      in_ready_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      err_invalid_q <= 1'b0;
      err_count_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      frame_len_q   <= frame_len_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
      err_invalid_q <= err_invalid_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.frame_out   = frame_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err_invalid = err_invalid_q;
  assign bus.err_count   = err_count_q;
  assign bus.dbg_state   = (state_q == HOLD);
endmodule

// File: doc/msg_packer.md
MSG_PACKER -- requirements
Module: msg_packer

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 6, meaning characters per output frame, legal range 2..64.
REQ-002 The block SHALL have parameter PAD_CHAR, default 8'h20, meaning fill byte for unused frame slots.
REQ-003 The block SHALL have parameter SUB_CHAR, default 8'h58 ("X"), meaning the replacement byte for invalid characters, used only under SANITIZE_EN.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port in_char, input, 8 bits, the incoming plaintext byte.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning in_char is offered.
REQ-008 The block SHALL have port in_last, input, 1 bit, meaning the offered byte ends the message; qualified by in_valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the byte is accepted when in_valid and in_ready are both high on a clock edge.
REQ-010 The block SHALL have port frame_out, output, 8*MSG_LEN bits, the packed frame for the encryptor; slot k occupies bits [8k+7:8k], and slot 0 holds the first character.
REQ-011 The block SHALL have port frame_len, output, $clog2(MSG_LEN+1) bits, the count of non-pad characters in frame_out.
REQ-012 The block SHALL have port frame_valid, output, 1 bit, meaning the frame is presented.
REQ-013 The block SHALL have port frame_ready, input, 1 bit, meaning the downstream encryptor takes the frame.
REQ-014 The block SHALL have port err_invalid, output, 1 bit, a one-cycle pulse per accepted invalid byte.
REQ-015 The block SHALL have port err_count, output, 8 bits, the saturating count of invalid bytes since reset.

Function
REQ-016 Valid characters SHALL be 8'h41-8'h5A ("A"-"Z"), 8'h61-8'h7A ("a"-"z"), and 8'h20 (space); every other byte is invalid.
REQ-017 The FSM SHALL have states FILL and HOLD; in_ready equals 1 in FILL and 0 in HOLD, and frame_valid equals 1 only in HOLD.
REQ-018 In FILL, an accepted valid byte SHALL be written to slot idx and idx SHALL increment.
REQ-019 An accepted invalid byte SHALL pulse err_invalid in the following cycle, increment err_count (saturating at 255), and SHALL NOT be stored or increment idx.
REQ-020 The frame SHALL close when a byte is stored into slot MSG_LEN-1, or when an accepted byte has in_last=1; this holds whether that byte was valid or invalid.
REQ-021 On close, slots idx..MSG_LEN-1 SHALL be loaded with PAD_CHAR, frame_len SHALL equal the stored-character count, and the FSM SHALL enter HOLD on the next edge.
REQ-022 Latency: frame_valid SHALL rise exactly one cycle after the edge that accepted the closing byte.
REQ-023 If a frame closes with zero stored characters (e.g. a lone invalid byte with in_last=1), no frame SHALL be emitted; the FSM stays in FILL with idx=0.
REQ-024 In HOLD, frame_out and frame_len SHALL be stable; on an edge with frame_ready=1, the FSM SHALL return to FILL with idx=0 and frame_valid=0 in the next cycle.
REQ-025 frame_ready while in FILL SHALL be ignored; in_valid while in HOLD SHALL be ignored, and the byte is not consumed.
REQ-026 Bytes after a full-frame close and before in_last SHALL start a new frame; frames never span a HOLD.

Reset
REQ-027 While rst_n=0, state SHALL be FILL, idx=0, in_ready=0, frame_valid=0, err_invalid=0, err_count=0, frame_len=0, and every frame_out slot = PAD_CHAR.
REQ-028 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-029 Reset asserted mid-fill or mid-HOLD SHALL discard the partial or pending frame immediately, with no frame_valid glitch.

Configuration
REQ-030 With macro MSG_PACKER_SANITIZE_EN defined, an accepted invalid byte SHALL be stored as SUB_CHAR and increment idx; err_invalid and err_count still update; REQ-023 then never triggers for invalid bytes.
REQ-031 Without MSG_PACKER_SANITIZE_EN, REQ-019 drop behaviour SHALL apply and the SUB_CHAR parameter is unused.

Verification
REQ-032 Send "HELLOW" with in_last on "W" -> one frame "HELLOW", frame_len=6, frame_valid one cycle after the "W" acceptance.
REQ-033 Send "Hi" with in_last on "i" -> frame "Hi" followed by four 8'h20, frame_len=2.
REQ-034 Send "@#$%^&" with in_last on "&", without macro -> six err_invalid pulses, err_count=6, no frame; with macro -> frame "XXXXXX", frame_len=6.
REQ-035 Fill a frame and hold frame_ready=0 for 10 cycles while in_valid=1 -> in_ready=0 and frame_out stable; raise frame_ready -> FILL next cycle, and the next byte lands in slot 0.
REQ-036 Assert rst_n=0 after 3 accepted bytes -> all outputs reach reset values without a clock; after release, a fresh 6-byte message produces a correct frame.
REQ-037 Drive 300 invalid bytes -> err_count saturates at 255.
